controlador_paridade_quadro: RTL and testbench

Frame-level controller for the serial even-parity detector (`DetectorParidadePar`). It accepts a parallel data word plus its received parity bit through a valid/ready handshake. It clears the detector, then feeds it the data bits LSB first followed by the parity bit. After the last bit it reports a per-frame pass/fail result and keeps a running error count. It sits between the word-level producer and the bit-serial detector instance, which it owns exclusively.

---
 rtl/controlador_paridade_quadro.sv | 92 +++++++++
 tb/tb_controlador_paridade_quadro.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/controlador_paridade_quadro.sv
// controlador_paridade_quadro: frame controller feeding a serial parity detector; define PARITY_ODD_EN for odd-parity frames
module controlador_paridade_quadro #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] word_in,
  input  logic              par_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              det_reset,
  output logic              det_bit,
  input  logic              det_odd,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_count
);
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, PARITY, CHECK} state_t;
`ifdef PARITY_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif
  state_t            r_state;
  logic [DATA_W-1:0] r_sh;
  logic              r_par;
  logic [5:0]        r_idx;
  logic              r_ready;
  logic              r_clr;
  logic              r_bit;
  logic              r_done;
  logic [7:0]        r_count;
  logic              w_err;
  assign w_err     = r_done & ~reset & (det_odd ^ ODD);
  assign ready_out = r_ready;
  assign det_reset = reset | r_clr;
  assign det_bit   = r_bit & ~reset;
  assign done      = r_done & ~reset;
  assign err       = w_err;
  assign err_count = reset ? 8'd0 : r_count;
  // frame sequencer: outputs are registered one state ahead so they line up with the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_clr   <= 1'b0;
      r_bit   <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: if (valid_in) begin
          r_sh    <= word_in;
          r_par   <= par_in;
          r_ready <= 1'b0;
          r_clr   <= 1'b1;
          r_state <= CLEAR;
        end
        CLEAR: begin
          r_clr   <= 1'b0;
          r_bit   <= r_sh[0];
          r_sh    <= r_sh >> 1;
          r_idx   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_idx <= r_idx + 6'd1;
          if (r_idx == 6'(DATA_W - 1)) begin
            r_bit   <= r_par;
            r_state <= PARITY;
          end else begin
            r_bit <= r_sh[0];
            r_sh  <= r_sh >> 1;
          end
        end
        PARITY: begin
          r_bit   <= 1'b0;
          r_done  <= 1'b1;
          r_state <= CHECK;
        end
        CHECK: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
          if (w_err && r_count != 8'hFF) r_count <= r_count + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_controlador_paridade_quadro.sv
// tb_controlador_paridade_quadro: randomized self-checking bench with a behavioural frame and detector model
module tb_controlador_paridade_quadro;
  localparam int DATA_W = 8;
`ifdef PARITY_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] word_in = '0;
  logic              par_in = 1'b0;
  logic              valid_in = 1'b0;
  logic              ready_out, det_reset, det_bit, det_odd, done, err;
  logic [7:0]        err_count;
  logic              det_state = 1'b0;
  int                cyc = 0;
  int                n_chk = 0;
  int                n_fail = 0;
  int                exp_cnt = 0;
  logic              obs_clr, obs_err, obs_ready, obs_stray;
  logic [DATA_W:0]   obs_bits;
  logic [7:0]        obs_cnt_pre, obs_cnt;
  int                obs_done_n, obs_done_at;
  logic              obs_timeout;

  controlador_paridade_quadro #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .word_in(word_in), .par_in(par_in), .valid_in(valid_in),
    .ready_out(ready_out), .det_reset(det_reset), .det_bit(det_bit), .det_odd(det_odd),
    .done(done), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) det_state <= det_reset ? 1'b0 : det_state ^ det_bit;
  assign det_odd = det_state;

  function automatic logic exp_err_of(input logic [DATA_W-1:0] w, input logic p);
    int ones = p;
    for (int i = 0; i < DATA_W; i++) ones += w[i];
    return ((ones % 2) == 1) ^ ODD;
  endfunction

  task automatic run_frame(input logic [DATA_W-1:0] w, input logic p);
    int n = 0;
    @(negedge clk);
    word_in = w; par_in = p; valid_in = 1'b1;
    obs_timeout = 1'b0;
    while (!ready_out && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) obs_timeout = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; word_in = DATA_W'($urandom); par_in = 1'($urandom);
    obs_clr = det_reset; obs_bits = '0; obs_done_n = 0; obs_done_at = -1; obs_err = 1'b0; obs_stray = 1'b0;
    for (int k = 2; k <= DATA_W + 4; k++) begin
      @(negedge clk);
      if (k <= DATA_W + 2) obs_bits[k-2] = det_bit;
      if (done) begin obs_done_n++; obs_done_at = k; obs_err = err; end
      else if (err) obs_stray = 1'b1;
      if (k == DATA_W + 3) obs_cnt_pre = err_count;
      if (k == DATA_W + 4) begin obs_cnt = err_count; obs_ready = ready_out; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (det_reset !== 1'b1) begin n_fail++; $display("FAIL reset_det_reset got %b want 1", det_reset); end
    n_chk++; if (done !== 1'b0 || err !== 1'b0 || det_bit !== 1'b0) begin n_fail++; $display("FAIL reset_outputs got done=%b err=%b bit=%b want 0 0 0", done, err, det_bit); end
    n_chk++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", err_count); end
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (ready_out !== 1'b1 || det_reset !== 1'b0) begin n_fail++; $display("FAIL reset_idle got ready=%b det_reset=%b want 1 0", ready_out, det_reset); end
    exp_cnt = 0;
  endtask

  task automatic test_frame(input logic [DATA_W-1:0] w, input logic p, input string nm);
    logic e = exp_err_of(w, p);
    run_frame(w, p);
    if (e && exp_cnt < 255) exp_cnt++;
    n_chk++; if (obs_timeout) begin n_fail++; $display("FAIL %s_handshake timed out", nm); end
    n_chk++; if (obs_clr !== 1'b1) begin n_fail++; $display("FAIL %s_clear got det_reset=%b want 1", nm, obs_clr); end
    n_chk++; if (obs_bits !== {p, w}) begin n_fail++; $display("FAIL %s_bits got %b want %b", nm, obs_bits, {p, w}); end
    n_chk++; if (obs_done_n !== 1 || obs_done_at !== DATA_W + 3) begin n_fail++; $display("FAIL %s_done got %0d pulses at t+%0d want 1 at t+%0d", nm, obs_done_n, obs_done_at, DATA_W + 3); end
    n_chk++; if (obs_err !== e || obs_stray) begin n_fail++; $display("FAIL %s_err got %b stray=%b want %b", nm, obs_err, obs_stray, e); end
    n_chk++; if (obs_cnt !== 8'(exp_cnt) || obs_ready !== 1'b1) begin n_fail++; $display("FAIL %s_count got %0d ready=%b want %0d 1", nm, obs_cnt, obs_ready, exp_cnt); end
  endtask

  task automatic test_directed();
    test_frame(8'h5A, 1'b0, "f5a");
    test_frame(8'h5B, 1'b0, "f5b");
    n_chk++; if (obs_cnt_pre !== 8'(exp_cnt - (exp_err_of(8'h5B, 1'b0) ? 1 : 0))) begin n_fail++; $display("FAIL f5b_count_late got %0d in CHECK want previous value", obs_cnt_pre); end
    test_frame(8'h01, 1'b1, "f01");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) test_frame(DATA_W'($urandom), 1'($urandom), "rand");
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] ws [3] = '{8'h00, 8'hFF, 8'h80};
    int hs [3];
    logic res [3];
    int nh = 0, nd = 0;
    @(negedge clk);
    word_in = ws[0]; par_in = 1'b0; valid_in = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (nh > 0 && cyc == hs[nh-1] + 1) begin
        if (nh < 3) begin word_in = ws[nh]; par_in = 1'b0; end else valid_in = 1'b0;
      end
      if (ready_out && valid_in && nh < 3) begin hs[nh] = cyc; nh++; end
      if (done && nd < 3) begin res[nd] = err; nd++; end
      @(negedge clk);
    end
    valid_in = 1'b0;
    n_chk++; if (nh !== 3 || nd !== 3) begin n_fail++; $display("FAIL b2b_counts got %0d handshakes %0d results want 3 3", nh, nd); end
    else begin
      n_chk++; if (hs[1] - hs[0] !== DATA_W + 4 || hs[2] - hs[1] !== DATA_W + 4) begin n_fail++; $display("FAIL b2b_spacing got %0d %0d want %0d", hs[1] - hs[0], hs[2] - hs[1], DATA_W + 4); end
      for (int i = 0; i < 3; i++) begin
        n_chk++; if (res[i] !== exp_err_of(ws[i], 1'b0)) begin n_fail++; $display("FAIL b2b_err%0d got %b want %b", i, res[i], exp_err_of(ws[i], 1'b0)); end
        if (exp_err_of(ws[i], 1'b0) && exp_cnt < 255) exp_cnt++;
      end
    end
    @(negedge clk);
    n_chk++; if (err_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", err_count, exp_cnt); end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    int nd = 0;
    @(negedge clk);
    word_in = 8'h01; par_in = 1'b0; valid_in = 1'b1;
    while (!ready_out && n < 50) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    valid_in = 1'b0;
    reset = 1'b1;
    #1;
    n_chk++; if (det_reset !== 1'b1 || done !== 1'b0 || det_bit !== 1'b0 || err_count !== 8'd0) begin n_fail++; $display("FAIL midrst_during got det_reset=%b done=%b bit=%b cnt=%0d want 1 0 0 0", det_reset, done, det_bit, err_count); end
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    n_chk++; if (ready_out !== 1'b1 || err_count !== 8'd0) begin n_fail++; $display("FAIL midrst_after got ready=%b cnt=%0d want 1 0", ready_out, err_count); end
    for (int c = 0; c < DATA_W + 6; c++) begin @(negedge clk); if (done) nd++; end
    n_chk++; if (nd !== 0) begin n_fail++; $display("FAIL midrst_nodone got %0d done pulses want 0", nd); end
    test_frame(8'h5B, 1'b0, "postrst");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      run_frame(8'h01, 1'b0);
      if (exp_err_of(8'h01, 1'b0) && exp_cnt < 255) exp_cnt++;
      n_chk++; if (obs_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL sat_count frame %0d got %0d want %0d", i, obs_cnt, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
